ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port RAM block: combinational read, write committed on CLK rising edge when CE=1.
- Port A is the CPU datapath; port B is the loader/DMA path.
- Grants one registered access at a time, round-robin on contention, and returns registered read data with a one-cycle ACK pulse.
- Sits between the requesters and the RAM instance; the RAM sees only registered control.

Parameters:
- ADDR_WIDTH, 8, RAM address width; must match the RAM instance.
- WIDTH, 8, data word width; must match the RAM instance.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A_REQ  input  1  port A request; held with A_WE/A_ADDR/A_WDATA stable until A_ACK.
- A_WE  input  1  port A access type: 1 = write, 0 = read.
- A_ADDR  input  ADDR_WIDTH  port A address.
- A_WDATA  input  WIDTH  port A write data.
- A_ACK  output  1  one-cycle pulse: port A access complete.
- A_RDATA  output  WIDTH  port A read data; valid when A_ACK=1, held until next A read.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_ACK, B_RDATA  same as A, for port B.
- BUSY  output  1  high while state is ACCESS.
- RAM_CE  output  1  to RAM CE (write enable).
- RAM_ADDR  output  ADDR_WIDTH  to RAM ADDR.
- RAM_DIN  output  WIDTH  to RAM DATA_IN.
- RAM_DOUT  input  WIDTH  from RAM DATA_OUT (combinational read).

Behaviour:
- Reset (async, RST_N=0): state=IDLE; RAM_CE=0; RAM_ADDR=0; RAM_DIN=0; A_ACK=B_ACK=0; A_RDATA=B_RDATA=0; BUSY=0; LAST=B, so A wins the first tie.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Compute eligible requests: X_REQ masked by X_ACK, so the requester just acked is ignored for that cycle.
  - Neither eligible: stay in IDLE; RAM_CE=0.
  - One eligible: grant it.
  - Both eligible: grant the port not equal to LAST.
  - On grant at the edge: OWNER <= winner; LAST <= winner; RAM_ADDR <= X_ADDR; RAM_DIN <= X_WDATA; RAM_CE <= X_WE; state <= ACCESS.
- ACCESS, exactly one cycle:
  - The RAM sees stable ADDR/DIN/CE for the full cycle.
  - At the closing edge:
    - If write: the RAM commits the data; RDATA unchanged.
    - If read: OWNER_RDATA <= RAM_DOUT.
    - OWNER_ACK <= 1; RAM_CE <= 0; state <= IDLE.
  - RAM_ADDR/RAM_DIN hold their last value.
- ACK is high exactly one cycle, the IDLE cycle after ACCESS, and clears next edge.
- Latency: REQ seen high at edge t (state IDLE, not masked) -> ACK high in cycle t+2. Minimum spacing is 2 cycles per access.
- Requester protocol:
  - Deassert REQ in the ACK cycle or later.
  - A REQ still high after the ACK cycle is a new request.
  - Changing REQ fields before ACK is illegal; the arbiter uses values latched at grant.
- Contention: strict alternation A,B,A,B while both hold requests. No starvation; worst-case wait is 4 cycles.
- Back-to-back: in an A_ACK cycle a pending B is granted the same edge.
- Reset mid-ACCESS: RAM_CE drops immediately (async), so the pending write is not committed. No ACK is produced; RDATA is cleared.
- Address wrap: none; addresses pass through unmodified across the full 0..2^ADDR_WIDTH-1 range.

Test Plan:
- Reset, then A write addr 0x10 data 0x5A -> RAM_CE=1 for exactly one cycle with RAM_ADDR=0x10, RAM_DIN=0x5A; A_ACK pulses at cycle t+2; B_ACK stays 0.
- A read 0x10 after the above -> A_RDATA=0x5A with A_ACK; B_RDATA remains 0x00.
- A and B requests raised the same cycle (A write 0x20=0x11, B write 0x21=0x22) -> A granted first (LAST=B after reset), B acked 2 cycles after A. Reads then return 0x11 and 0x22.
- Both hold continuous read requests for 8 accesses -> ACKs alternate A,B,A,B,...; each port acked every 4 cycles; BUSY toggles 1,0.
- RST_N asserted during ACCESS of a B write 0x30=0xFF (address previously 0x00) -> RAM_CE drops immediately, no B_ACK; a later read of 0x30 returns 0x00.
- A holds A_REQ high through its ACK cycle with B idle -> no grant in the ACK cycle; re-granted the next cycle; second A_ACK arrives 3 cycles after the first.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port RAM.
// The master side is the requester/RAM environment; the slave side is the arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
);
    logic                  A_REQ;
    logic                  A_WE;
    logic [ADDR_WIDTH-1:0] A_ADDR;
    logic [WIDTH-1:0]      A_WDATA;
    logic                  A_ACK;
    logic [WIDTH-1:0]      A_RDATA;

    logic                  B_REQ;
    logic                  B_WE;
    logic [ADDR_WIDTH-1:0] B_ADDR;
    logic [WIDTH-1:0]      B_WDATA;
    logic                  B_ACK;
    logic [WIDTH-1:0]      B_RDATA;

    logic                  BUSY;
    logic                  RAM_CE;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [WIDTH-1:0]      RAM_DIN;
    logic [WIDTH-1:0]      RAM_DOUT;

    modport master (
        output A_REQ, A_WE, A_ADDR, A_WDATA,
        output B_REQ, B_WE, B_ADDR, B_WDATA,
        output RAM_DOUT,
        input  A_ACK, A_RDATA, B_ACK, B_RDATA,
        input  BUSY, RAM_CE, RAM_ADDR, RAM_DIN
    );

    modport slave (
        input  A_REQ, A_WE, A_ADDR, A_WDATA,
        input  B_REQ, B_WE, B_ADDR, B_WDATA,
        input  RAM_DOUT,
        output A_ACK, A_RDATA, B_ACK, B_RDATA,
        output BUSY, RAM_CE, RAM_ADDR, RAM_DIN
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port RAM; every
// output is a flop (or a decode of one), so the RAM only ever sees registered control.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | pick an eligible requester, latch its fields into RAM_*
//   ST_ACCESS | RAM holds ADDR/DIN/CE for one full cycle; ack owner at exit
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    ram_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic [0:0]            state;
    logic                  owner;
    logic                  last;
    logic                  a_ack_q;
    logic                  b_ack_q;
    logic [WIDTH-1:0]      a_rdata_q;
    logic [WIDTH-1:0]      b_rdata_q;
    logic                  ram_ce_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [WIDTH-1:0]      ram_din_q;

    logic                  a_elig;
    logic                  b_elig;
    logic                  grant_any;
    logic                  winner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;

    // A port that was acked this cycle is masked so a held REQ is not re-granted
    // before the requester has had a chance to drop it.
    always_comb begin
        a_elig    = bus.A_REQ & ~a_ack_q;
        b_elig    = bus.B_REQ & ~b_ack_q;
        grant_any = a_elig | b_elig;
        winner    = PORT_A;
        if (a_elig && b_elig) begin
            winner = ~last;
        end else if (b_elig) begin
            winner = PORT_B;
        end
        sel_we    = bus.A_WE;
        sel_addr  = bus.A_ADDR;
        sel_wdata = bus.A_WDATA;
        if (winner == PORT_B) begin
            sel_we    = bus.B_WE;
            sel_addr  = bus.B_ADDR;
            sel_wdata = bus.B_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            owner      <= PORT_A;
            last       <= PORT_B;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ram_ce_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            if (state == ST_IDLE) begin
                ram_ce_q <= 1'b0;
                if (grant_any) begin
                    owner      <= winner;
                    last       <= winner;
                    ram_addr_q <= sel_addr;
                    ram_din_q  <= sel_wdata;
                    ram_ce_q   <= sel_we;
                    state      <= ST_ACCESS;
                end
            end else begin
                // RAM_CE still carries the access type latched at grant.
                if (!ram_ce_q) begin
                    if (owner == PORT_A) begin
                        a_rdata_q <= bus.RAM_DOUT;
                    end else begin
                        b_rdata_q <= bus.RAM_DOUT;
                    end
                end
                if (owner == PORT_A) begin
                    a_ack_q <= 1'b1;
                end else begin
                    b_ack_q <= 1'b1;
                end
                ram_ce_q <= 1'b0;
                state    <= ST_IDLE;
            end
        end
    end

    assign bus.A_ACK    = a_ack_q;
    assign bus.B_ACK    = b_ack_q;
    assign bus.A_RDATA  = a_rdata_q;
    assign bus.B_RDATA  = b_rdata_q;
    assign bus.BUSY     = (state == ST_ACCESS);
    assign bus.RAM_CE   = ram_ce_q;
    assign bus.RAM_ADDR = ram_addr_q;
    assign bus.RAM_DIN  = ram_din_q;

endmodule
